demux_1to4: RTL and testbench

- 1:4 demultiplexer: routes data input i to exactly one of four outputs y0..y3, selected by sel0/sel1.
- Built as a two-level tree of 1:2 demux cells: the first level is steered by sel0, the second level by sel1.
- Optional output register stage, clocked by clk with asynchronous active-low reset rst_n.
- Used as a generic routing leaf in combinational/datapath fabric.

---
 rtl/demux_pkg.sv | 13 +
 rtl/demux_1to4_if.sv | 23 ++
 rtl/demux_1_2.sv | 14 +
 rtl/demux_1to4.sv | 72 +++++++
 tb/tb_demux_1to4.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared constants and output index names for the 1:4 demux tree.
package demux_pkg;

  localparam int SEL_W = 2;

  typedef enum logic [SEL_W-1:0] {
    Y0 = 2'd0,
    Y1 = 2'd1,
    Y2 = 2'd2,
    Y3 = 2'd3
  } out_idx_e;

endpackage

// File: rtl/demux_1to4_if.sv
// Select/data bundle for the 1:4 demux. The master drives select and data,
// the slave (the demux) drives the four routed outputs.
interface demux_1to4_if #(
  parameter int WIDTH = 1
);
  logic             sel0;
  logic             sel1;
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y3;

  modport master (
    output sel0, sel1, i,
    input  y0, y1, y2, y3
  );

  modport slave (
    input  sel0, sel1, i,
    output y0, y1, y2, y3
  );
endinterface

// File: rtl/demux_1_2.sv
// 1:2 demux cell; the unselected leg is driven to zero rather than held.
module demux_1_2 #(
  parameter int WIDTH = 1
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1
);

  assign y0 = sel ? '0 : i;
  assign y1 = sel ? i  : '0;

endmodule

// File: rtl/demux_1to4.sv
// 1:4 demux built as a two-level tree of 1:2 cells (sel0 steers level 1,
// sel1 steers level 2), with an optional output register stage.
module demux_1to4
  import demux_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int OUT_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  demux_1to4_if.slave   bus
);

  logic [SEL_W-1:0]         sel_idx;
  logic [WIDTH-1:0]         branch_a;
  logic [WIDTH-1:0]         branch_b;
  logic [3:0][WIDTH-1:0]    tree_y;

  // sel0 is the MSB of the select index
  assign sel_idx = {bus.sel0, bus.sel1};

  demux_1_2 #(.WIDTH(WIDTH)) u_lvl1 (
    .sel (sel_idx[SEL_W-1]),
    .i   (bus.i),
    .y0  (branch_a),
    .y1  (branch_b)
  );

  demux_1_2 #(.WIDTH(WIDTH)) u_lvl2_a (
    .sel (sel_idx[0]),
    .i   (branch_a),
    .y0  (tree_y[Y0]),
    .y1  (tree_y[Y1])
  );

  demux_1_2 #(.WIDTH(WIDTH)) u_lvl2_b (
    .sel (sel_idx[0]),
    .i   (branch_b),
    .y0  (tree_y[Y2]),
    .y1  (tree_y[Y3])
  );

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [3:0][WIDTH-1:0] y_q;

      // Capture the whole tree output each edge; reset clears all legs at once
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_q <= '0;
        end else begin
          y_q <= tree_y;
        end
      end

      assign bus.y0 = y_q[Y0];
      assign bus.y1 = y_q[Y1];
      assign bus.y2 = y_q[Y2];
      assign bus.y3 = y_q[Y3];
    end else begin : g_comb
      // Clock and reset have no role in the combinational variant
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign bus.y0 = tree_y[Y0];
      assign bus.y1 = tree_y[Y1];
      assign bus.y2 = tree_y[Y2];
      assign bus.y3 = tree_y[Y3];
    end
  endgenerate

endmodule

// File: tb/tb_demux_1to4.sv
// Directed and random checks of demux_1to4 in four configurations:
// WIDTH 1/8 crossed with combinational/registered outputs.
module tb_demux_1to4;

  logic       clk;
  logic       rst_n;
  logic       sel0;
  logic       sel1;
  logic       d1;
  logic [7:0] d8;

  int total = 0;
  int bad   = 0;

  demux_1to4_if #(.WIDTH(1)) if_c1 ();
  demux_1to4_if #(.WIDTH(1)) if_r1 ();
  demux_1to4_if #(.WIDTH(8)) if_c8 ();
  demux_1to4_if #(.WIDTH(8)) if_r8 ();

  assign if_c1.sel0 = sel0;  assign if_c1.sel1 = sel1;  assign if_c1.i = d1;
  assign if_r1.sel0 = sel0;  assign if_r1.sel1 = sel1;  assign if_r1.i = d1;
  assign if_c8.sel0 = sel0;  assign if_c8.sel1 = sel1;  assign if_c8.i = d8;
  assign if_r8.sel0 = sel0;  assign if_r8.sel1 = sel1;  assign if_r8.i = d8;

  demux_1to4 #(.WIDTH(1), .OUT_REG(0)) u_c1 (.clk(clk), .rst_n(rst_n), .bus(if_c1));
  demux_1to4 #(.WIDTH(1), .OUT_REG(1)) u_r1 (.clk(clk), .rst_n(rst_n), .bus(if_r1));
  demux_1to4 #(.WIDTH(8), .OUT_REG(0)) u_c8 (.clk(clk), .rst_n(rst_n), .bus(if_c8));
  demux_1to4 #(.WIDTH(8), .OUT_REG(1)) u_r8 (.clk(clk), .rst_n(rst_n), .bus(if_r8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: output n carries data only when the select index equals n
  function automatic logic [7:0] ref_y(input int n, input logic [1:0] s, input logic [7:0] d);
    return (int'(s) == n) ? d : 8'h00;
  endfunction

  task automatic check_c1(input string tag, input logic [1:0] s, input logic d);
    check({tag, ".c1.y0"}, {7'd0, if_c1.y0}, ref_y(0, s, {7'd0, d}));
    check({tag, ".c1.y1"}, {7'd0, if_c1.y1}, ref_y(1, s, {7'd0, d}));
    check({tag, ".c1.y2"}, {7'd0, if_c1.y2}, ref_y(2, s, {7'd0, d}));
    check({tag, ".c1.y3"}, {7'd0, if_c1.y3}, ref_y(3, s, {7'd0, d}));
  endtask

  task automatic check_c8(input string tag, input logic [1:0] s, input logic [7:0] d);
    check({tag, ".c8.y0"}, if_c8.y0, ref_y(0, s, d));
    check({tag, ".c8.y1"}, if_c8.y1, ref_y(1, s, d));
    check({tag, ".c8.y2"}, if_c8.y2, ref_y(2, s, d));
    check({tag, ".c8.y3"}, if_c8.y3, ref_y(3, s, d));
    check({tag, ".c8.or"}, if_c8.y0 | if_c8.y1 | if_c8.y2 | if_c8.y3, d);
  endtask

  task automatic check_r(input string tag, input logic [1:0] s, input logic d, input logic [7:0] w);
    check({tag, ".r1.y0"}, {7'd0, if_r1.y0}, ref_y(0, s, {7'd0, d}));
    check({tag, ".r1.y1"}, {7'd0, if_r1.y1}, ref_y(1, s, {7'd0, d}));
    check({tag, ".r1.y2"}, {7'd0, if_r1.y2}, ref_y(2, s, {7'd0, d}));
    check({tag, ".r1.y3"}, {7'd0, if_r1.y3}, ref_y(3, s, {7'd0, d}));
    check({tag, ".r8.y0"}, if_r8.y0, ref_y(0, s, w));
    check({tag, ".r8.y1"}, if_r8.y1, ref_y(1, s, w));
    check({tag, ".r8.y2"}, if_r8.y2, ref_y(2, s, w));
    check({tag, ".r8.y3"}, if_r8.y3, ref_y(3, s, w));
    check({tag, ".r8.or"}, if_r8.y0 | if_r8.y1 | if_r8.y2 | if_r8.y3, w);
  endtask

  task automatic check_r_zero(input string tag);
    check_r(tag, 2'b00, 1'b0, 8'h00);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] s_now;
    logic       d_now;
    logic [7:0] w_now;

    rst_n = 1'b0;
    sel0  = 1'b0;
    sel1  = 1'b0;
    d1    = 1'b0;
    d8    = 8'h00;

    // Reset state of the registered variants, with live data at their inputs
    #2;
    sel0 = 1'b1; sel1 = 1'b1; d1 = 1'b1; d8 = 8'hFF;
    @(posedge clk); #1;
    check_r_zero("reset_hold");

    @(negedge clk);
    sel0 = 1'b0; sel1 = 1'b0; d1 = 1'b0; d8 = 8'h00;
    rst_n = 1'b1;

    // Exhaustive combinational sweep of (sel0, sel1, i), WIDTH=1
    for (int k = 0; k < 8; k++) begin
      sel0 = k[2]; sel1 = k[1]; d1 = k[0];
      #1;
      check_c1($sformatf("sweep%0d", k), {sel0, sel1}, d1);
    end

    // Wide data across all four selects, combinational
    d8 = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      sel0 = k[1]; sel1 = k[0];
      #1;
      check_c8($sformatf("wide%0d", k), {sel0, sel1}, d8);
    end

    // Registered latency: known all-zero sample first, then sel=10, i=1
    @(negedge clk);
    sel0 = 1'b0; sel1 = 1'b0; d1 = 1'b0; d8 = 8'h00;
    @(posedge clk); #1;
    check_r_zero("lat_pre_zero");
    @(negedge clk);
    sel0 = 1'b1; sel1 = 1'b0; d1 = 1'b1; d8 = 8'hA5;
    #1;
    check_r_zero("lat_before_edge");
    @(posedge clk); #1;
    check_r("lat_after_edge", 2'b10, 1'b1, 8'hA5);

    // Mid-cycle select change has no effect until the next edge
    @(negedge clk);
    sel1 = 1'b1;
    #1;
    check_r("mid_hold", 2'b10, 1'b1, 8'hA5);
    @(posedge clk); #1;
    check_r("mid_next_edge", 2'b11, 1'b1, 8'hA5);

    // Async reset between edges while y3 is set
    #2;
    rst_n = 1'b0;
    #1;
    check_r_zero("arst_immediate");
    @(posedge clk); #1;
    check_r_zero("arst_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_r_zero("arst_release_no_edge");
    @(posedge clk); #1;
    check_r("arst_first_capture", 2'b11, 1'b1, 8'hA5);

    // Random traffic: combinational checked right after drive, registered
    // checked after the following edge against what was driven
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      s_now = 2'($urandom_range(0, 3));
      d_now = 1'($urandom_range(0, 1));
      w_now = 8'($urandom_range(0, 255));
      sel0 = s_now[1]; sel1 = s_now[0]; d1 = d_now; d8 = w_now;
      #1;
      check_c1("rnd", s_now, d_now);
      check_c8("rnd", s_now, w_now);
      @(posedge clk); #1;
      check_r("rnd", s_now, d_now, w_now);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
